tt_um_xelef2000: RTL and testbench
==================================

// Module: tt_um_xelef2000
// PURPOSE
//  TinyTapeout user tile: 8-bit programmable timer/counter with PWM output.
//  Host writes four 8-bit registers through ui_in and uio_in[2:0]. The core
//  drives the counter value on uo_out, and PWM, wrap tick and status on uio[7:4].
//  The block is the top level of the tile, instantiated directly by the TT harness.
// PARAMETERS
//  none (all widths fixed at 8 bits)
// PORTS
//  clk      in   1  system clock; the single clock domain
//  rst_n    in   1  reset; synchronous, active-high (asserted = 1, despite the suffix)
//  ena      in   1  tile enable; 0 freezes all state (no writes, no counting)
//  ui_in    in   8  write data
//  uo_out   out  8  current counter value CNT
//  uio_in   in   8  [1:0] reg select, [2] write strobe, [7:3] ignored
//  uio_out  out  8  [3:0]=0, [4] pwm, [5] tick, [6] CTRL.run, [7] CTRL.down
//  uio_oe   out  8  constant 8'hF0 (uio[3:0] inputs, uio[7:4] outputs)
// BEHAVIOUR
//  - Registers (select = uio_in[1:0]):
//    00 CTRL (bit0 run, bit1 down, bits7:2 read-as-0)
//    01 DUTY
//    10 PRESC
//    11 CNT
//  - Reset (rst_n=1 at a clk edge): CTRL=0, DUTY=0, PRESC=0, CNT=0,
//    prescale counter PCNT=0, wr_q=0, tick=0. Resulting outputs: uo_out=0, uio_out=0.
//    Reset has priority over ena and over writes, and aborts any operation in progress.
//  - Write strobe is edge detected: wr_q <= uio_in[2] every enabled cycle.
//    A write fires when ena & uio_in[2] & ~wr_q.
//    Data comes from ui_in, sampled at that edge; the new value is visible on the next cycle.
//    A strobe held high produces exactly one write.
//  - Counting: when ena & run, PCNT increments each cycle. When PCNT==PRESC,
//    PCNT<=0 and CNT steps once: +1, or -1 if down. So CNT steps every PRESC+1 cycles.
//    PRESC=0 means CNT steps every cycle.
//  - Wrap: up 0xFF->0x00 or down 0x00->0xFF. On a wrap, tick=1 for exactly the one
//    cycle following the step; otherwise tick=0.
//  - A write to CNT loads the value, clears PCNT, suppresses that cycle's step, and
//    raises no tick. Write wins over a simultaneous step.
//  - A write to PRESC clears PCNT.
//  - A write to CTRL clearing run stops counting on the same edge; CNT and PCNT hold.
//  - pwm = (CNT < DUTY), combinational from registers:
//    DUTY=0 gives pwm constantly 0; DUTY=0xFF gives pwm 0 only at CNT=0xFF.
//  - ena=0: all registers hold, including wr_q and PCNT. tick is cleared to 0.
//    Outputs keep reflecting the held state.
// STRUCTURE
//  - Shared package tt_xelef_pkg holds:
//    register-select localparams REG_CTRL/REG_DUTY/REG_PRESC/REG_CNT,
//    CTRL bit indices, reset constants, UIO_OE_VAL = 8'hF0.
//  - One sub-module xelef_prescaler (PCNT compare, clear and step-pulse
//    generation). Counter, register file and PWM compare stay in the top level.
// TESTING
//  1 Reset: hold rst_n=1 for 2 cycles with garbage on ui_in/uio_in
//    -> uo_out=0x00, uio_out=0x00, uio_oe=0xF0.
//  2 Write CTRL=0x01, PRESC=0 -> uo_out counts 0,1,2... one per clock.
//    Run to 0xFF->0x00 -> uio_out[5] high exactly 1 cycle.
//  3 PRESC=3, run=1 -> CNT steps every 4 clocks.
//    Hold strobe high 10 cycles with sel=11, data 0x10 -> single write; CNT=0x10 afterwards.
//  4 DUTY=0x40, up-count through a full period -> pwm high for exactly 64 of 256 steps.
//    DUTY=0 -> pwm never high.
//  5 CTRL=0x03 from CNT=0x00 -> next value 0xFF with tick.
//    Write CNT=0x05 on a step cycle -> CNT=0x05, no tick.
//  6 ena=0 mid-count with strobes toggling -> CNT, registers frozen, no writes.
//    ena=1 -> counting resumes from the held CNT/PCNT.
//    Reset mid-count -> all state 0 next cycle.

Source files
------------

// File: rtl/tt_xelef_pkg.sv
// rtl/tt_xelef_pkg.sv - shared constants for the xelef timer/counter tile
package tt_xelef_pkg;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_DUTY  = 2'd1;
    localparam logic [1:0] REG_PRESC = 2'd2;
    localparam logic [1:0] REG_CNT   = 2'd3;

    localparam int CTRL_RUN  = 0;
    localparam int CTRL_DOWN = 1;
    localparam int WR_STROBE = 2;

    localparam logic [1:0] CTRL_RST  = 2'b00;
    localparam logic [7:0] DUTY_RST  = 8'h00;
    localparam logic [7:0] PRESC_RST = 8'h00;
    localparam logic [7:0] CNT_RST   = 8'h00;
    localparam logic [7:0] PCNT_RST  = 8'h00;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/xelef_prescaler.sv
// rtl/xelef_prescaler.sv - prescale counter producing one step pulse every presc+1 running cycles
module xelef_prescaler
    import tt_xelef_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       run,
    input  logic       clr,
    input  logic [7:0] presc,
    output logic       step
);

    logic [7:0] pcnt;
    logic       hit;

    always_comb begin
        hit  = (pcnt == presc);
        step = ena & run & hit;
    end

    // clr (CNT/PRESC write) restarts the prescale period even while stopped
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= PCNT_RST;
        end else if (ena) begin
            if (clr) begin
                pcnt <= PCNT_RST;
            end else if (run) begin
                pcnt <= hit ? 8'h00 : pcnt + 8'h01;
            end
        end
    end

endmodule

// File: rtl/tt_um_xelef2000.sv
// rtl/tt_um_xelef2000.sv - TinyTapeout tile: 8-bit programmable timer/counter with PWM
module tt_um_xelef2000
    import tt_xelef_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [1:0] ctrl;
    logic [7:0] duty;
    logic [7:0] presc;
    logic [7:0] cnt;
    logic       wr_q;
    logic       tick;

    logic [1:0] sel;
    logic       fire;
    logic       wr_ctrl;
    logic       wr_duty;
    logic       wr_presc;
    logic       wr_cnt;
    logic       run_eff;
    logic       step_raw;
    logic       step;
    logic       wrap;
    logic       pwm;

    logic unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:3]};

    always_comb begin
        sel      = uio_in[1:0];
        fire     = ena & uio_in[WR_STROBE] & ~wr_q;
        wr_ctrl  = fire & (sel == REG_CTRL);
        wr_duty  = fire & (sel == REG_DUTY);
        wr_presc = fire & (sel == REG_PRESC);
        wr_cnt   = fire & (sel == REG_CNT);
        // a CTRL write that clears run must already block this edge's step
        run_eff  = ctrl[CTRL_RUN] & ~(wr_ctrl & ~ui_in[CTRL_RUN]);
        step     = step_raw & ~wr_cnt;
        wrap     = ctrl[CTRL_DOWN] ? (cnt == 8'h00) : (cnt == 8'hFF);
        pwm      = (cnt < duty);
    end

    xelef_prescaler u_presc (
        .clk   (clk),
        .rst   (rst_n),
        .ena   (ena),
        .run   (run_eff),
        .clr   (wr_cnt | wr_presc),
        .presc (presc),
        .step  (step_raw)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ctrl  <= CTRL_RST;
            duty  <= DUTY_RST;
            presc <= PRESC_RST;
            cnt   <= CNT_RST;
            wr_q  <= 1'b0;
            tick  <= 1'b0;
        end else if (ena) begin
            wr_q <= uio_in[WR_STROBE];
            if (wr_ctrl)  ctrl  <= ui_in[1:0];
            if (wr_duty)  duty  <= ui_in;
            if (wr_presc) presc <= ui_in;
            if (wr_cnt) begin
                cnt <= ui_in;
            end else if (step) begin
                cnt <= ctrl[CTRL_DOWN] ? cnt - 8'h01 : cnt + 8'h01;
            end
            tick <= step & wrap;
        end else begin
            tick <= 1'b0;
        end
    end

    assign uo_out  = cnt;
    assign uio_out = {ctrl[CTRL_DOWN], ctrl[CTRL_RUN], tick, pwm, 4'b0000};
    assign uio_oe  = UIO_OE_VAL;

endmodule

// File: tb/tb_tt_um_xelef2000.sv
// tb/tb_tt_um_xelef2000.sv - directed vector bench for the xelef timer/counter tile
module tb_tt_um_xelef2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;

    tt_um_xelef2000 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       do_wr;
        logic [1:0] sel;
        logic [7:0] data;
        int         cycles;
        logic [7:0] exp_cnt;
        logic [7:0] exp_uio;
        string      name;
    } vec_t;

    vec_t vecs[11];

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data);
        ui_in  = data;
        uio_in = {5'b0, 1'b1, sel};
        cycle();
        uio_in = 8'h00;
        cycle();
    endtask

    task automatic count_pwm(input string name, input int exp);
        int hi = 0;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (uio_out[4]) hi++;
        end
        check(name, hi, exp);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 2'd2, 8'h00,   0, 8'h00, 8'h00, "presc0"};
        vecs[1]  = '{1'b1, 2'd0, 8'h01,   0, 8'h01, 8'h40, "run_first_step"};
        vecs[2]  = '{1'b0, 2'd0, 8'h00,   3, 8'h04, 8'h40, "count_every_clk"};
        vecs[3]  = '{1'b0, 2'd0, 8'h00, 251, 8'hFF, 8'h40, "reach_ff"};
        vecs[4]  = '{1'b0, 2'd0, 8'h00,   1, 8'h00, 8'h60, "wrap_tick"};
        vecs[5]  = '{1'b0, 2'd0, 8'h00,   1, 8'h01, 8'h40, "tick_one_cycle"};
        vecs[6]  = '{1'b1, 2'd2, 8'h03,   0, 8'h02, 8'h40, "presc3_write"};
        vecs[7]  = '{1'b0, 2'd0, 8'h00,   2, 8'h02, 8'h40, "presc3_hold"};
        vecs[8]  = '{1'b0, 2'd0, 8'h00,   1, 8'h03, 8'h40, "presc3_step1"};
        vecs[9]  = '{1'b0, 2'd0, 8'h00,   3, 8'h03, 8'h40, "presc3_hold2"};
        vecs[10] = '{1'b0, 2'd0, 8'h00,   1, 8'h04, 8'h40, "presc3_step2"};

        rst_n  = 1'b1;
        ena    = 1'b1;
        ui_in  = 8'hA5;
        uio_in = 8'hFF;
        cycle();
        cycle();
        check("reset_uo", uo_out, 8'h00);
        check("reset_uio", uio_out, 8'h00);
        check("reset_oe", uio_oe, 8'hF0);
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        for (int v = 0; v < 11; v++) begin
            if (vecs[v].do_wr) wr(vecs[v].sel, vecs[v].data);
            for (int c = 0; c < vecs[v].cycles; c++) cycle();
            check({vecs[v].name, "_cnt"}, uo_out, vecs[v].exp_cnt);
            check({vecs[v].name, "_uio"}, uio_out, vecs[v].exp_uio);
        end

        // strobe held high for 10 cycles: one CNT load, then counting continues
        ui_in  = 8'h10;
        uio_in = 8'h07;
        cycle();
        check("held_wr_load", uo_out, 8'h10);
        for (int i = 0; i < 9; i++) cycle();
        check("held_wr_single", uo_out, 8'h12);
        uio_in = 8'h00;
        cycle();
        check("held_wr_release", uo_out, 8'h12);
        wr(2'd0, 8'h00);
        check("stop_holds", uo_out, 8'h12);

        wr(2'd2, 8'h00);
        wr(2'd1, 8'h40);
        wr(2'd0, 8'h01);
        count_pwm("pwm_duty40", 64);
        wr(2'd1, 8'h00);
        count_pwm("pwm_duty00", 0);
        wr(2'd1, 8'hFF);
        count_pwm("pwm_dutyff", 255);

        wr(2'd1, 8'h00);
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h01);
        wr(2'd0, 8'h03);
        check("down_to_0", uo_out, 8'h00);
        check("down_to_0_uio", uio_out, 8'hC0);
        cycle();
        check("down_wrap_cnt", uo_out, 8'hFF);
        check("down_wrap_tick", uio_out, 8'hE0);
        cycle();
        check("down_after_wrap", uo_out, 8'hFE);
        check("down_tick_clear", uio_out, 8'hC0);

        wr(2'd0, 8'h02);
        wr(2'd3, 8'h01);
        wr(2'd0, 8'h03);
        check("pre_wr_step", uo_out, 8'h00);
        ui_in  = 8'h05;
        uio_in = 8'h07;
        cycle();
        check("wr_wins_cnt", uo_out, 8'h05);
        check("wr_wins_notick", uio_out, 8'hC0);
        uio_in = 8'h00;
        cycle();
        check("after_wr_step", uo_out, 8'h04);

        wr(2'd2, 8'h03);
        cycle();
        check("pre_freeze", uo_out, 8'h03);
        ena = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ui_in  = 8'hAA;
            uio_in = {5'b0, i[0], 2'b11};
            cycle();
            check("freeze_cnt", uo_out, 8'h03);
            check("freeze_uio", uio_out, 8'hC0);
        end
        uio_in = 8'h00;
        ui_in  = 8'h00;
        ena    = 1'b1;
        cycle();
        check("resume_pcnt_held", uo_out, 8'h03);
        cycle();
        check("resume_step", uo_out, 8'h02);

        rst_n = 1'b1;
        ena   = 1'b0;
        cycle();
        check("midreset_uo", uo_out, 8'h00);
        check("midreset_uio", uio_out, 8'h00);
        rst_n = 1'b0;
        ena   = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("post_reset_idle", uo_out, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
